pll_phase_ctrl: RTL and testbench
=================================

Name: pll_phase_ctrl

Overview:
- Dynamic phase-shift controller for the ECP5 EHXPLLL dynamic phase port (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG).
- Generalises our fixed-phase PLL setup to run-time per-output phase adjustment across up to 4 outputs, with per-channel absolute phase tracking and post-shift lock check.
- Sits beside the PLL instance and is driven by training/calibration logic through a valid/ready request port.

Parameters:
- NUM_CH, 2: number of controllable PLL outputs, 1..4. Channel index equals PHASESEL code (0=CLKOS, 1=CLKOS2, 2=CLKOS3, 3=CLKOP).
- STEPS: 40: phase steps per output period (8 x CLKOP_DIV). Even, >= 2.
- PW: $clog2(STEPS): phase/target width (derived).
- STEP_W: 4: cycles phasestep is held high per step.
- GAP_W: 4: cycles phasestep is held low between steps.
- LOCK_TO: 4096: cycles to wait for lock after the last step.

Ports:
- clk  in  1  controller clock (PLL input-domain clock)
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_ch  in  2  target channel
- req_target  in  PW  absolute phase target, 0..STEPS-1
- done  out  1  one-cycle completion pulse
- err_arg  out  1  qualifies done: request rejected
- err_lock  out  1  qualifies done: lock timeout
- busy  out  1  high in every state except IDLE
- cur_phase  out  NUM_CH*PW  tracked phase per channel, flattened, ch0 in LSBs
- pll_locked  in  1  PLL LOCK, asynchronous
- phasesel  out  2  to PHASESEL[1:0]
- phasedir  out  1  to PHASEDIR (0 = delay/increment, 1 = advance/decrement)
- phasestep  out  1  to PHASESTEP
- phaseloadreg  out  1  to PHASELOADREG, constant 0

Behaviour:
- Reset values: req_ready=1 once reset releases, done=0, err_arg=0, err_lock=0, busy=0, phasesel=0, phasedir=0, phasestep=0, phaseloadreg=0, all cur_phase=0. Phase 0 is defined as the static CPHASE/FPHASE setting.
- Accept on req_valid & req_ready. ch and target are latched, and the controller leaves IDLE on the next edge.
- States:
  - IDLE: waits for an accepted request.
  - CALC (1 cycle): if req_ch >= NUM_CH or req_target >= STEPS, go to DONE with err_arg=1 and leave cur_phase unchanged.
    - Otherwise compute d = (target - cur[ch]) mod STEPS in PW+1 bits.
    - d = 0: go to DONE with no error and no strobes.
    - d <= STEPS/2: dir=0, n=d.
    - Else: dir=1, n=STEPS-d.
    - The tie at STEPS/2 resolves to increment.
    - phasesel and phasedir are driven from CALC onward and stay stable until DONE, at least one cycle before the first phasestep rise.
  - STEP_HI: phasestep=1 for STEP_W cycles.
    - On exit, cur[ch] is updated by ±1 with modulo STEPS wrap (STEPS-1 +1 -> 0; 0 -1 -> STEPS-1), and n is decremented.
  - STEP_LO: phasestep=0 for GAP_W cycles. Then go to STEP_HI if n != 0, else WAIT_LOCK.
  - WAIT_LOCK: waits for the 2-FF-synchronised lock to be high.
    - The lock check starts after GAP_W cycles have elapsed, so the in-flight drop is observed.
    - Lock high: go to DONE.
    - LOCK_TO cycles elapse first: go to DONE with err_lock=1.
  - DONE (1 cycle): done=1 with err flags valid for this cycle only. Next state is IDLE.
- Latency: d=0 gives done 2 cycles after accept. Otherwise done follows after 1 + n*(STEP_W+GAP_W) + lock wait cycles.
- cur_phase counts issued steps even if the lock times out. The caller resynchronises by reset.
- req_valid while busy is ignored (ready=0), and request inputs are not sampled.
- Lock loss during stepping does not abort the sequence; it is judged only in WAIT_LOCK.
- Async reset mid-step: phasestep drops immediately and cur_phase returns to 0. The PLL must be reset by the same reset source so that the hardware phase matches.

Decomposition:
- Package pll_phase_pkg:
  - state enum (IDLE, CALC, STEP_HI, STEP_LO, WAIT_LOCK, DONE)
  - PHASESEL channel constants (SEL_CLKOS=0 .. SEL_CLKOP=3)
  - DIR_INC/DIR_DEC constants
- One sub-module, sync_2ff, for pll_locked, reusable elsewhere.
- Step/gap timer and lock timeout share one counter sized for max(STEP_W, GAP_W, LOCK_TO).

Test Plan:
- Reset, then STEPS=40, ch0 target 10 -> 10 phasestep pulses, each STEP_W high/GAP_W low; phasedir=0, phasesel=0; done after lock; cur_phase[ch0]=10.
- From 0, ch1 target 35 -> 5 pulses with phasedir=1, phasesel=1; cur_phase[ch1]=35 (wrap 0->39 observed after the first step).
- From 0, target 20 (tie) -> 20 increments, phasedir=0. Then the same target again -> done 2 cycles after accept, no pulses.
- Target 45, or req_ch=2 with NUM_CH=2 -> done with err_arg=1, no pulses, cur_phase unchanged, req_ready back to 1 the next cycle.
- pll_locked held low after the steps -> done with err_lock=1 exactly LOCK_TO cycles after the WAIT_LOCK check starts; cur_phase reflects the issued steps.
- rst_n asserted during STEP_HI of the 3rd step -> phasestep=0 asynchronously, all outputs at reset values; a request after release is accepted normally.

Source files
------------

// File: rtl/pll_phase_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pll_phase_pkg                                              |
// | Brief    : Shared types and constants for the PLL phase controller    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package pll_phase_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CALC      = 3'd1,
        STEP_HI   = 3'd2,
        STEP_LO   = 3'd3,
        WAIT_LOCK = 3'd4,
        DONE      = 3'd5
    } state_t;

    // PHASESEL codes of the EHXPLLL dynamic phase port
    localparam logic [1:0] SEL_CLKOS  = 2'd0;
    localparam logic [1:0] SEL_CLKOS2 = 2'd1;
    localparam logic [1:0] SEL_CLKOS3 = 2'd2;
    localparam logic [1:0] SEL_CLKOP  = 2'd3;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_2ff                                                   |
// | Brief    : Two-flop synchroniser for asynchronous level inputs        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pll_phase_ctrl                                             |
// | Brief    : Run-time phase stepping controller for EHXPLLL outputs     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int STEPS   = 40,
    parameter int PW      = $clog2(STEPS),
    parameter int STEP_W  = 4,
    parameter int GAP_W   = 4,
    parameter int LOCK_TO = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_ch,
    input  logic [PW-1:0]      req_target,
    output logic               done,
    output logic               err_arg,
    output logic               err_lock,
    output logic               busy,
    output logic [NUM_CH*PW-1:0] cur_phase,
    input  logic               pll_locked,
    output logic [1:0]         phasesel,
    output logic               phasedir,
    output logic               phasestep,
    output logic               phaseloadreg
);

    localparam int c_sg_max  = (STEP_W > GAP_W) ? STEP_W : GAP_W;
    localparam int c_cnt_max = (c_sg_max > LOCK_TO) ? c_sg_max : LOCK_TO;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_step_ld = c_cnt_w'(STEP_W - 1);
    localparam logic [c_cnt_w-1:0] c_gap_ld  = c_cnt_w'(GAP_W - 1);
    localparam logic [c_cnt_w-1:0] c_lock_ld = c_cnt_w'(LOCK_TO - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [PW:0]        c_steps   = (PW+1)'(STEPS);
    localparam logic [PW:0]        c_half    = (PW+1)'(STEPS / 2);
    localparam logic [PW-1:0]      c_ph_max  = PW'(STEPS - 1);
    localparam logic [PW-1:0]      c_ph_one  = PW'(1);
    localparam logic [2:0]         c_num_ch  = 3'(NUM_CH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [PW-1:0]       r_n;
    logic [PW-1:0]       w_n_nxt;
    logic [1:0]          r_ch;
    logic                r_dir;
    logic                r_bad;
    logic                r_err_arg;
    logic                r_err_lock;
    logic                r_step;
    logic                w_err_arg_nxt;
    logic                w_err_lock_nxt;
    logic                w_step_en;
    logic                w_lock;
    logic                w_accept;

    logic [PW-1:0]       w_cur_req;
    logic [PW:0]         w_tgt_ext;
    logic [PW:0]         w_cur_ext;
    logic [PW:0]         w_diff;
    logic                w_bad_req;
    logic                w_dir_req;
    logic [PW-1:0]       w_n_req;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_lock)
    );

    assign w_accept = req_valid && (r_state == IDLE);

    always_comb begin
        w_cur_req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_ch == 2'(c)) begin
                w_cur_req = cur_phase[c*PW +: PW];
            end
        end
    end

    // Shortest-path distance, modulo STEPS; the half-period tie goes to increment
    assign w_tgt_ext = {1'b0, req_target};
    assign w_cur_ext = {1'b0, w_cur_req};
    assign w_diff    = (w_tgt_ext >= w_cur_ext) ? (w_tgt_ext - w_cur_ext)
                                                : (w_tgt_ext + c_steps - w_cur_ext);
    assign w_bad_req = ({1'b0, req_ch} >= c_num_ch) || (w_tgt_ext >= c_steps);
    assign w_dir_req = (w_diff > c_half) ? DIR_DEC : DIR_INC;
    assign w_n_req   = (w_diff > c_half) ? PW'(c_steps - w_diff) : PW'(w_diff);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_n_nxt        = r_n;
        w_step_en      = 1'b0;
        w_err_arg_nxt  = 1'b0;
        w_err_lock_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_bad) begin
                    w_state_nxt   = DONE;
                    w_err_arg_nxt = 1'b1;
                end else if (r_n == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = STEP_HI;
                    w_cnt_nxt   = c_step_ld;
                end
            end
            STEP_HI: begin
                if (r_cnt == '0) begin
                    w_state_nxt = STEP_LO;
                    w_cnt_nxt   = c_gap_ld;
                    w_step_en   = 1'b1;
                    w_n_nxt     = r_n - c_ph_one;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            STEP_LO: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (r_n != '0) begin
                    w_state_nxt = STEP_HI;
                    w_cnt_nxt   = c_step_ld;
                end else begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = c_lock_ld;
                end
            end
            WAIT_LOCK: begin
                if (w_lock) begin
                    w_state_nxt = DONE;
                end else if (r_cnt == '0) begin
                    w_state_nxt    = DONE;
                    w_err_lock_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_n        <= '0;
            r_ch       <= SEL_CLKOS;
            r_dir      <= DIR_INC;
            r_bad      <= 1'b0;
            r_err_arg  <= 1'b0;
            r_err_lock <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_arg  <= w_err_arg_nxt;
            r_err_lock <= w_err_lock_nxt;
            r_step     <= (w_state_nxt == STEP_HI);
            // sel/dir are latched at accept so they lead the first strobe
            if (w_accept) begin
                r_ch  <= req_ch;
                r_dir <= w_dir_req;
                r_n   <= w_n_req;
                r_bad <= w_bad_req;
            end else begin
                r_n <= w_n_nxt;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PW-1:0] r_ph;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ph <= '0;
            end else if (w_step_en && (r_ch == 2'(g))) begin
                if (r_dir == DIR_INC) begin
                    r_ph <= (r_ph == c_ph_max) ? '0 : r_ph + c_ph_one;
                end else begin
                    r_ph <= (r_ph == '0) ? c_ph_max : r_ph - c_ph_one;
                end
            end
        end

        assign cur_phase[g*PW +: PW] = r_ph;
    end

    assign req_ready    = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign err_arg      = r_err_arg;
    assign err_lock     = r_err_lock;
    assign phasesel     = r_ch;
    assign phasedir     = r_dir;
    assign phasestep    = r_step;
    assign phaseloadreg = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pll_phase_ctrl                                          |
// | Brief    : Scoreboard bench for pll_phase_ctrl (STEPS=40, 2 channels) |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pll_phase_ctrl;

    localparam int NUM_CH  = 2;
    localparam int STEPS   = 40;
    localparam int PW      = 6;
    localparam int STEP_W  = 4;
    localparam int GAP_W   = 4;
    localparam int LOCK_TO = 4096;

    typedef struct {
        bit         ea;
        bit         el;
        int         pulses;
        bit         dir;
        logic [1:0] sel;
        int         first;
        logic [11:0] cur;
        int         lat;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_ch;
    logic [PW-1:0]     req_target;
    logic              done;
    logic              err_arg;
    logic              err_lock;
    logic              busy;
    logic [NUM_CH*PW-1:0] cur_phase;
    logic              pll_locked;
    logic [1:0]        phasesel;
    logic              phasedir;
    logic              phasestep;
    logic              phaseloadreg;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   acc_cyc;
    int   mon_pulses;
    int   hi_cnt;
    int   lo_cnt;
    bit   prev_step;
    bit   ready_chk;

    pll_phase_ctrl #(
        .NUM_CH  (NUM_CH),
        .STEPS   (STEPS),
        .PW      (PW),
        .STEP_W  (STEP_W),
        .GAP_W   (GAP_W),
        .LOCK_TO (LOCK_TO)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_ch       (req_ch),
        .req_target   (req_target),
        .done         (done),
        .err_arg      (err_arg),
        .err_lock     (err_lock),
        .busy         (busy),
        .cur_phase    (cur_phase),
        .pll_locked   (pll_locked),
        .phasesel     (phasesel),
        .phasedir     (phasedir),
        .phasestep    (phasestep),
        .phaseloadreg (phaseloadreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: pulse shape, sel/dir at each rise, and scoreboard pop on done
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pulses = 0;
            hi_cnt     = 0;
            lo_cnt     = 0;
            prev_step  = 1'b0;
            ready_chk  = 1'b0;
        end else begin
            if (ready_chk) begin
                check("req_ready after done", int'(req_ready), 1);
                ready_chk = 1'b0;
            end
            if (phasestep && !prev_step) begin
                mon_pulses++;
                if (exp_q.size() > 0) begin
                    check("phasesel at step", int'(phasesel), int'(exp_q[0].sel));
                    check("phasedir at step", int'(phasedir), int'(exp_q[0].dir));
                end else begin
                    check("unexpected phasestep", 1, 0);
                end
                if (mon_pulses > 1) check("phasestep low gap", lo_cnt, GAP_W);
                hi_cnt = 1;
            end else if (phasestep) begin
                hi_cnt++;
            end else if (prev_step) begin
                check("phasestep high width", hi_cnt, STEP_W);
                if (mon_pulses == 1 && exp_q.size() > 0)
                    check("phase after first step",
                          int'(cur_phase[int'(phasesel)*PW +: PW]), exp_q[0].first);
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            prev_step = phasestep;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done without request", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("err_arg", int'(err_arg), int'(m_e.ea));
                    check("err_lock", int'(err_lock), int'(m_e.el));
                    check("pulse count", mon_pulses, m_e.pulses);
                    check("cur_phase", int'(cur_phase), int'(m_e.cur));
                    check("latency", cyc - acc_cyc + 1, m_e.lat);
                end
                mon_pulses = 0;
                ready_chk  = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            check("completion timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [1:0] ch, input logic [5:0] tgt);
        @(negedge clk);
        req_valid  = 1'b1;
        req_ch     = ch;
        req_target = tgt;
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        // keep valid asserted with junk while busy: must be ignored
        req_ch     = ~ch;
        req_target = 6'd45;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] ch, input logic [5:0] tgt, input bit lock_ok,
                          input bit ea, input bit el, input int np, input bit dir,
                          input int first, input logic [5:0] p0, input logic [5:0] p1,
                          input int lat);
        exp_t e;
        e.ea = ea; e.el = el; e.pulses = np; e.dir = dir; e.sel = ch;
        e.first = first; e.cur = {p1, p0}; e.lat = lat;
        pll_locked = lock_ok;
        exp_q.push_back(e);
        issue(ch, tgt);
        wait_idle();
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst req_ready", int'(req_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst err_arg", int'(err_arg), 0);
        check("rst err_lock", int'(err_lock), 0);
        check("rst phasesel", int'(phasesel), 0);
        check("rst phasedir", int'(phasedir), 0);
        check("rst phasestep", int'(phasestep), 0);
        check("rst phaseloadreg", int'(phaseloadreg), 0);
        check("rst cur_phase", int'(cur_phase), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        acc_cyc    = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_ch     = 2'd0;
        req_target = '0;
        pll_locked = 1'b1;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        //     ch    tgt    lock ea el  n   dir first ph0    ph1    latency
        do_req(2'd0, 6'd10, 1,   0, 0, 10, 0,  1,    6'd10, 6'd0,  83);
        do_req(2'd1, 6'd35, 1,   0, 0, 5,  1,  39,   6'd10, 6'd35, 43);
        do_req(2'd0, 6'd30, 1,   0, 0, 20, 0,  11,   6'd30, 6'd35, 163);
        do_req(2'd0, 6'd30, 1,   0, 0, 0,  0,  0,    6'd30, 6'd35, 2);
        do_req(2'd0, 6'd45, 1,   1, 0, 0,  0,  0,    6'd30, 6'd35, 2);
        do_req(2'd2, 6'd5,  1,   1, 0, 0,  0,  0,    6'd30, 6'd35, 2);
        do_req(2'd3, 6'd0,  1,   1, 0, 0,  0,  0,    6'd30, 6'd35, 2);
        do_req(2'd1, 6'd0,  1,   0, 0, 5,  0,  36,   6'd30, 6'd0,  43);
        do_req(2'd0, 6'd2,  0,   0, 1, 12, 0,  31,   6'd2,  6'd0,  4194);
        do_req(2'd1, 6'd39, 1,   0, 0, 1,  1,  39,   6'd2,  6'd39, 11);

        // Reset in the middle of the third step of ch1 39 -> 4
        begin
            exp_t e;
            e.ea = 0; e.el = 0; e.pulses = 5; e.dir = 0; e.sel = 2'd1;
            e.first = 0; e.cur = 12'd0; e.lat = 43;
            exp_q.push_back(e);
        end
        issue(2'd1, 6'd4);
        for (int i = 0; i < 200 && mon_pulses < 3; i++) begin
            @(negedge clk);
            #1;
        end
        check("reached third step", mon_pulses, 3);
        check("third step high", int'(phasestep), 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_req(2'd0, 6'd20, 1,   0, 0, 20, 0,  1,    6'd20, 6'd0,  163);
        do_req(2'd0, 6'd20, 1,   0, 0, 0,  0,  0,    6'd20, 6'd0,  2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
